maze_timer_bar: RTL and testbench

Countdown game timer that drives the time-bar column input of the VGA frame renderer, sitting directly upstream of it. The debounced control pulse starts a round. The bar shrinks by one block per tick period. The maze controller's win pulse freezes the bar. Expiry raises a time-up flag that the maze controller consumes to end the round.

---
 rtl/maze_timer_bar.sv | 116 +++++++++++
 tb/tb_maze_timer_bar.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_timer_bar.sv
// Countdown round timer feeding the renderer's time-bar column; the bar shrinks one block per tick.
// Optional warning blink near expiry is built only when MAZE_TIMER_WARN_EN is defined.
module maze_timer_bar #(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned BAR_FULL    = 40,
    parameter int unsigned WARN_BLOCKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic [5:0] o_bar_bcol,
    output logic       o_time_up,
    output logic       o_running,
    output logic       o_warn
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [5:0] BAR_RELOAD = 6'(BAR_FULL);

    if (TICK_CYCLES < 2 || (TICK_CYCLES % 2) != 0 || BAR_FULL < 1 || BAR_FULL > 63 ||
        WARN_BLOCKS > 63) begin : g_param_check
        $error("maze_timer_bar: parameter out of range");
    end

    typedef enum logic [2:0] {StIdle, StRun, StPause, StFrozen, StExpired} state_e;

    state_e          state_q;
    logic [5:0]      bar_q;
    logic [PW-1:0]   presc_q;
    logic            running_q;
    logic            time_up_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bar_q     <= BAR_RELOAD;
            presc_q   <= '0;
            running_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            // Status flags trail the state register by one cycle.
            running_q <= (state_q == StRun);
            time_up_q <= (state_q == StExpired);
            if (i_start) begin
                state_q <= StRun;
                bar_q   <= BAR_RELOAD;
                presc_q <= '0;
            end else begin
                case (state_q)
                    StRun: begin
                        if (i_stop) begin
                            state_q <= StFrozen;
                        end else if (i_pause) begin
                            state_q <= StPause;
                        end else if (presc_q == TICK_LAST) begin
                            presc_q <= '0;
                            if (bar_q <= 6'd1) begin
                                bar_q   <= 6'd0;
                                state_q <= StExpired;
                            end else begin
                                bar_q <= bar_q - 6'd1;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    StPause: begin
                        if (i_stop) begin
                            state_q <= StFrozen;
                        end else if (i_pause) begin
                            state_q <= StRun;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_bar_bcol = bar_q;
    assign o_time_up  = time_up_q;
    assign o_running  = running_q;

`ifdef MAZE_TIMER_WARN_EN
    localparam logic [PW-1:0] TICK_HALF  = PW'(TICK_CYCLES / 2 - 1);
    localparam logic [5:0]    WARN_LEVEL = 6'(WARN_BLOCKS);

    logic warn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else if (i_start) begin
            warn_q <= 1'b0;
        end else if (state_q == StRun) begin
            // A tick that expires the round clears rather than toggles.
            if (i_stop || (!i_pause && presc_q == TICK_LAST && bar_q <= 6'd1)) begin
                warn_q <= 1'b0;
            end else if (!i_pause && bar_q <= WARN_LEVEL &&
                         (presc_q == TICK_HALF || presc_q == TICK_LAST)) begin
                warn_q <= ~warn_q;
            end
        end else if (state_q != StPause || i_stop) begin
            warn_q <= 1'b0;
        end
    end

    assign o_warn = warn_q;
`else
    assign o_warn = 1'b0;
`endif

endmodule

// File: tb/tb_maze_timer_bar.sv
// Directed bench for maze_timer_bar with TICK_CYCLES=4, BAR_FULL=3, WARN_BLOCKS=1.
// Warn expectations follow MAZE_TIMER_WARN_EN; without it o_warn must stay 0.
module tb_maze_timer_bar;

    localparam int unsigned TICK = 4;
    localparam int unsigned FULL = 3;
    localparam int unsigned WARN = 1;
`ifdef MAZE_TIMER_WARN_EN
    localparam bit WarnEn = 1'b1;
`else
    localparam bit WarnEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_stop = 1'b0;
    logic [5:0] o_bar_bcol;
    logic       o_time_up;
    logic       o_running;
    logic       o_warn;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    maze_timer_bar #(
        .TICK_CYCLES(TICK),
        .BAR_FULL   (FULL),
        .WARN_BLOCKS(WARN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_pause   (i_pause),
        .i_stop    (i_stop),
        .o_bar_bcol(o_bar_bcol),
        .o_time_up (o_time_up),
        .o_running (o_running),
        .o_warn    (o_warn)
    );

    // All tasks start and end right after a falling edge.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd2) $display("FAIL pre_reset_bar: got %0d expected 2", o_bar_bcol);
        else n_pass++;
        n_total++;
        if (o_running !== 1'b1) $display("FAIL pre_reset_running: got %b expected 1", o_running);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL reset_bar: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        n_total++;
        if (o_time_up !== 1'b0) $display("FAIL reset_time_up: got %b expected 0", o_time_up);
        else n_pass++;
        n_total++;
        if (o_running !== 1'b0) $display("FAIL reset_running: got %b expected 0", o_running);
        else n_pass++;
        n_total++;
        if (o_warn !== 1'b0) $display("FAIL reset_warn: got %b expected 0", o_warn);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_run();
        int   exp_bar;
        logic exp_warn;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n_total++;
        if (o_running !== 1'b0) $display("FAIL run_running_n0: got %b expected 0", o_running);
        else n_pass++;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_bar  = (k >= 12) ? 0 : 3 - k / 4;
            exp_warn = WarnEn && (k == 10 || k == 11);
            n_total++;
            if (o_bar_bcol !== 6'(exp_bar))
                $display("FAIL run_bar k=%0d: got %0d expected %0d", k, o_bar_bcol, exp_bar);
            else n_pass++;
            n_total++;
            if (o_warn !== exp_warn)
                $display("FAIL run_warn k=%0d: got %b expected %b", k, o_warn, exp_warn);
            else n_pass++;
            if (k == 1 || k == 12 || k == 13) begin
                n_total++;
                if (o_running !== (k != 13))
                    $display("FAIL run_running k=%0d: got %b expected %b", k, o_running, k != 13);
                else n_pass++;
                n_total++;
                if (o_time_up !== (k == 13))
                    $display("FAIL run_time_up k=%0d: got %b expected %b", k, o_time_up, k == 13);
                else n_pass++;
            end
        end
    endtask

    task automatic test_restart();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL restart_bar: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_time_up !== 1'b0) $display("FAIL restart_time_up: got %b expected 0", o_time_up);
        else n_pass++;
        n_total++;
        if (o_running !== 1'b1) $display("FAIL restart_running: got %b expected 1", o_running);
        else n_pass++;
    endtask

    task automatic test_pause();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_total++;
            if (o_bar_bcol !== 6'd3)
                $display("FAIL pause_hold_bar k=%0d: got %0d expected 3", k, o_bar_bcol);
            else n_pass++;
        end
        n_total++;
        if (o_running !== 1'b0) $display("FAIL pause_running: got %b expected 0", o_running);
        else n_pass++;
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL resume_bar_1: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        n_total++;
        if (o_running !== 1'b1) $display("FAIL resume_running: got %b expected 1", o_running);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd2) $display("FAIL resume_bar_2: got %0d expected 2", o_bar_bcol);
        else n_pass++;
    endtask

    task automatic test_stop_tick();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL stop_bar: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_running !== 1'b0) $display("FAIL stop_running: got %b expected 0", o_running);
        else n_pass++;
        n_total++;
        if (o_time_up !== 1'b0) $display("FAIL stop_time_up: got %b expected 0", o_time_up);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            i_pause = 1'b1;
            @(negedge clk);
            i_pause = 1'b0;
            repeat (3) @(negedge clk);
            n_total++;
            if (o_running !== 1'b0)
                $display("FAIL frozen_pause_running k=%0d: got %b expected 0", k, o_running);
            else n_pass++;
            n_total++;
            if (o_bar_bcol !== 6'd3)
                $display("FAIL frozen_pause_bar k=%0d: got %0d expected 3", k, o_bar_bcol);
            else n_pass++;
        end
    endtask

    task automatic test_start_over_stop();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd1) $display("FAIL sos_pre_bar: got %0d expected 1", o_bar_bcol);
        else n_pass++;
        n_total++;
        if (o_warn !== WarnEn) $display("FAIL sos_pre_warn: got %b expected %b", o_warn, WarnEn);
        else n_pass++;
        i_start = 1'b1;
        i_stop  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL sos_bar: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        n_total++;
        if (o_warn !== 1'b0) $display("FAIL sos_warn: got %b expected 0", o_warn);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_running !== 1'b1) $display("FAIL sos_running: got %b expected 1", o_running);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd3) $display("FAIL sos_bar_hold: got %0d expected 3", o_bar_bcol);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_bar_bcol !== 6'd2) $display("FAIL sos_bar_tick: got %0d expected 2", o_bar_bcol);
        else n_pass++;
    endtask

    task automatic test_warn_pause();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_pause = 1'b1;
        @(negedge clk);
        i_pause = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if (o_warn !== WarnEn) $display("FAIL warn_pause_hold: got %b expected %b", o_warn, WarnEn);
        else n_pass++;
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        n_total++;
        if (o_warn !== 1'b0) $display("FAIL warn_frozen_clear: got %b expected 0", o_warn);
        else n_pass++;
        n_total++;
        if (o_bar_bcol !== 6'd1) $display("FAIL warn_frozen_bar: got %0d expected 1", o_bar_bcol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_restart();
        test_pause();
        test_stop_tick();
        test_start_over_stop();
        test_warn_pause();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
